// File: rtl/ui_input_conditioner.sv
// Raw key/switch front end: two-flop synchronisers, per-bit debouncers, key press/release
// pulses with optional auto-repeat, and a single change strobe for the switch bank.
module ui_input_conditioner #(
    parameter int              NBTN              = 4,
    parameter int              NSW               = 10,
    parameter int              DEBOUNCE_CYC      = 1000000,
    parameter int              REPEAT_DELAY_CYC  = 25000000,
    parameter int              REPEAT_PERIOD_CYC = 5000000,
    parameter logic [NBTN-1:0] REPEAT_MASK       = NBTN'(4'b0011)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NBTN-1:0] key_n,
    input  logic [NSW-1:0]  sw_raw,
    output logic [NBTN-1:0] btn_level,
    output logic [NBTN-1:0] btn_press,
    output logic [NBTN-1:0] btn_release,
    output logic [NSW-1:0]  sw_clean,
    output logic            sw_changed
);

    localparam int NIN  = NBTN + NSW;
    localparam int CW   = $clog2(DEBOUNCE_CYC);
    localparam int RMAX = (REPEAT_DELAY_CYC > REPEAT_PERIOD_CYC) ? REPEAT_DELAY_CYC : REPEAT_PERIOD_CYC;
    localparam int RW   = $clog2(RMAX);

    // Released/low level of every raw input; keys idle high, switches idle low.
    localparam logic [NIN-1:0] IDLE_RAW    = {{NSW{1'b0}}, {NBTN{1'b1}}};
    localparam logic [CW-1:0]  DB_LAST     = CW'(DEBOUNCE_CYC - 1);
    localparam logic [RW-1:0]  DELAY_LAST  = RW'(REPEAT_DELAY_CYC - 1);
    localparam logic [RW-1:0]  PERIOD_LAST = RW'(REPEAT_PERIOD_CYC - 1);

    typedef enum logic [1:0] {IDLE, HELD, REPEAT} key_state_e;

    logic [NIN-1:0]  s1_q, s1_d, s2_q, s2_d;
    logic [NIN-1:0]  active;
    logic [NIN-1:0]  stable;
    logic [NBTN-1:0] rise, fall;
    logic [NSW-1:0]  sw_prev_q, sw_prev_d;
    logic            sw_changed_q, sw_changed_d;

    always_comb begin
        s1_d = {sw_raw, key_n};
        s2_d = s1_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= IDLE_RAW;
            s2_q <= IDLE_RAW;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    // Normalise so that 1 always means pressed / up.
    assign active = s2_q ^ IDLE_RAW;

    genvar gi;
    generate
        for (gi = 0; gi < NIN; gi++) begin : g_db
            logic [CW-1:0] cnt_q, cnt_d;
            logic          stable_q, stable_d;

            always_comb begin
                cnt_d    = '0;
                stable_d = stable_q;
                if (active[gi] != stable_q) begin
                    if (cnt_q == DB_LAST) begin
                        stable_d = active[gi];
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_q    <= '0;
                    stable_q <= 1'b0;
                end else begin
                    cnt_q    <= cnt_d;
                    stable_q <= stable_d;
                end
            end

            assign stable[gi] = stable_q;

            // Edges are taken from the next stable value so the key pulses line up with it.
            if (gi < NBTN) begin : g_edge
                assign rise[gi] = stable_d & ~stable_q;
                assign fall[gi] = ~stable_d & stable_q;
            end
        end

        for (gi = 0; gi < NBTN; gi++) begin : g_key
            key_state_e    state_q, state_d;
            logic [RW-1:0] rpt_q, rpt_d;
            logic          press_q, press_d;
            logic          release_q, release_d;

            always_comb begin
                state_d   = state_q;
                rpt_d     = rpt_q;
                press_d   = 1'b0;
                release_d = 1'b0;
                case (state_q)
                    IDLE: begin
                        if (rise[gi]) begin
                            state_d = HELD;
                            press_d = 1'b1;
                            rpt_d   = '0;
                        end
                    end
                    HELD: begin
                        if (fall[gi]) begin
                            state_d   = IDLE;
                            release_d = 1'b1;
                            rpt_d     = '0;
                        end else if (REPEAT_MASK[gi] && (rpt_q == DELAY_LAST)) begin
                            state_d = REPEAT;
                            press_d = 1'b1;
                            rpt_d   = '0;
                        end else if (rpt_q != {RW{1'b1}}) begin
                            rpt_d = rpt_q + 1'b1;
                        end
                    end
                    REPEAT: begin
                        if (fall[gi]) begin
                            state_d   = IDLE;
                            release_d = 1'b1;
                            rpt_d     = '0;
                        end else if (rpt_q == PERIOD_LAST) begin
                            press_d = 1'b1;
                            rpt_d   = '0;
                        end else begin
                            rpt_d = rpt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        rpt_d   = '0;
                    end
                endcase
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    state_q   <= IDLE;
                    rpt_q     <= '0;
                    press_q   <= 1'b0;
                    release_q <= 1'b0;
                end else begin
                    state_q   <= state_d;
                    rpt_q     <= rpt_d;
                    press_q   <= press_d;
                    release_q <= release_d;
                end
            end

            assign btn_level[gi]   = (state_q != IDLE);
            assign btn_press[gi]   = press_q;
            assign btn_release[gi] = release_q;
        end
    endgenerate

    assign sw_clean = stable[NIN-1:NBTN];

    always_comb begin
        sw_prev_d    = sw_clean;
        sw_changed_d = (sw_clean != sw_prev_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sw_prev_q    <= '0;
            sw_changed_q <= 1'b0;
        end else begin
            sw_prev_q    <= sw_prev_d;
            sw_changed_q <= sw_changed_d;
        end
    end

    assign sw_changed = sw_changed_q;

endmodule
